vram_mp: RTL

Parametrised, multi-client video RAM controller. It is the next generation of the 320x240x16 frame-buffer RAM and sits between the CPU/blitter bus masters and the display scan-out.
- Port A is shared by NUM_CH requesters through a round-robin arbiter and adds per-byte write enables.
- Port A also carries a hardware fill engine for clears and solid rectangles.
- Port B is a dedicated read-only scan-out port that never stalls.

---
 rtl/vram_mp.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vram_mp.sv
// vram_mp: multi-client frame-buffer RAM. Port A is shared round-robin between NUM_CH
// requesters plus a solid-fill engine; port B is a never-stalling scan-out read port.
module vram_mp #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 17,
    parameter int DEPTH      = 76800,
    parameter int NUM_CH     = 2,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_CH-1:0]            ch_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
    input  logic [NUM_CH*BE_W-1:0]       ch_be,
    output logic [NUM_CH-1:0]            ch_gnt,
    output logic [NUM_CH-1:0]            ch_rvalid,
    output logic [DATA_WIDTH-1:0]        ch_rdata,
    input  logic [ADDR_WIDTH-1:0]        disp_addr,
    output logic [DATA_WIDTH-1:0]        disp_rdata,
    input  logic                         fill_start,
    input  logic [ADDR_WIDTH-1:0]        fill_base,
    input  logic [ADDR_WIDTH-1:0]        fill_count,
    input  logic [DATA_WIDTH-1:0]        fill_value,
    output logic                         fill_busy,
    output logic                         fill_done
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {IDLE, FILL} fill_state_t;

    fill_state_t           state;
    logic [RR_W-1:0]       rr;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [ADDR_WIDTH-1:0] fill_left;
    logic [DATA_WIDTH-1:0] fill_val;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  gnt_any;
    logic [RR_W-1:0]       gnt_idx;
    int                    cand;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [BE_W-1:0]       sel_be;
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_W-1:0]       wr_be;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        ch_gnt  = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        if (!reset && state == IDLE) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = (int'(rr) + i) % NUM_CH;
                if (!gnt_any && ch_req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = RR_W'(cand);
                end
            end
            ch_gnt[gnt_idx] = gnt_any;
        end
    end

    assign sel_we    = ch_we[gnt_idx];
    assign sel_addr  = ch_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = ch_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_be    = ch_be[gnt_idx*BE_W +: BE_W];
    assign rd_en     = gnt_any && !sel_we;

    // The fill engine owns the write port while in FILL; channels are never granted then.
    always_comb begin
        wr_addr = sel_addr;
        wr_data = sel_wdata;
        wr_be   = sel_be;
        wr_en   = gnt_any && sel_we && in_range(sel_addr);
        if (state == FILL) begin
            wr_addr = fill_addr;
            wr_data = fill_val;
            wr_be   = '1;
            wr_en   = !reset && in_range(fill_addr);
        end
    end

    // NOTE: the array itself is never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BE_W; k++) begin
                if (wr_be[k]) mem[wr_addr][k*8 +: 8] <= wr_data[k*8 +: 8];
            end
        end
    end

    // Both read ports sample the array before this edge's write lands (read-before-write).
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_rvalid  <= '0;
            ch_rdata   <= '0;
            disp_rdata <= '0;
        end else begin
            ch_rvalid <= rd_en ? ch_gnt : '0;
            if (rd_en) ch_rdata <= in_range(sel_addr) ? mem[sel_addr] : '0;
            disp_rdata <= in_range(disp_addr) ? mem[disp_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= '0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
            fill_addr <= '0;
            fill_left <= '0;
            fill_val  <= '0;
        end else begin
            fill_done <= 1'b0;
            if (gnt_any) rr <= (gnt_idx == RR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
            case (state)
                IDLE: begin
                    if (fill_start) begin
                        fill_addr <= fill_base;
                        fill_left <= fill_count;
                        fill_val  <= fill_value;
                        if (fill_count != '0) begin
                            state     <= FILL;
                            fill_busy <= 1'b1;
                        end else begin
                            fill_done <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    fill_addr <= fill_addr + 1'b1;
                    fill_left <= fill_left - 1'b1;
                    if (fill_left == ADDR_WIDTH'(1)) begin
                        state     <= IDLE;
                        fill_busy <= 1'b0;
                        fill_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
